// File: rtl/blk_69f224.sv
// Deadlock report unit: picks an origin process, traces the token ring
// back to it and hands a report (origin, visited mask, length) to software.
module blk_69f224 #(
    parameter int PROC_NUM = 4,
    parameter int CNT_W    = 8
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic [PROC_NUM-1:0] proc_token_vec,
    input  logic                dl_clear,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [4:0]          rpt_origin_id,
    output logic [PROC_NUM-1:0] rpt_proc_mask,
    output logic [CNT_W-1:0]    rpt_len,
    output logic                rpt_abort
);

    typedef enum logic [2:0] {
        IDLE,
        ORIGIN,
        TRACE,
        REPORT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          origin_q, origin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROC_NUM-1:0] vis_q, vis_d;
    logic [4:0]          rid_q, rid_d;
    logic [PROC_NUM-1:0] rmask_q, rmask_d;
    logic [CNT_W-1:0]    rlen_q, rlen_d;

    logic [4:0]          first_idx;
    logic                tok_at_origin;
    logic                cnt_max;
    logic [CNT_W-1:0]    cnt_inc;

    always_comb begin
        first_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_in_vec[i]) first_idx = 5'(i);
        end
        tok_at_origin = 1'b0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (origin_q == 5'(i)) tok_at_origin = proc_token_vec[i];
        end
    end

    // Counter and reported length both saturate at all-ones.
    assign cnt_max = &cnt_q;
    assign cnt_inc = cnt_max ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        origin_d      = origin_q;
        cnt_d         = cnt_q;
        vis_d         = vis_q;
        rid_d         = rid_q;
        rmask_d       = rmask_q;
        rlen_d        = rlen_q;
        dl_detect_out = (state_q != IDLE);
        origin_vec    = '0;
        token_clear   = 1'b0;
        rpt_valid     = 1'b0;
        rpt_abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|dl_in_vec) begin
                    origin_d = first_idx;
                    state_d  = ORIGIN;
                end
            end
            ORIGIN: begin
                origin_vec = {{(PROC_NUM-1){1'b0}}, 1'b1} << origin_q;
                cnt_d      = '0;
                vis_d      = '0;
                state_d    = TRACE;
            end
            TRACE: begin
                vis_d       = vis_q | proc_token_vec;
                cnt_d       = cnt_inc;
                token_clear = tok_at_origin;
                if (tok_at_origin) begin
                    rlen_d  = cnt_inc;
                    rmask_d = vis_q | proc_token_vec;
                    rid_d   = origin_q;
                    state_d = REPORT;
                end else if (cnt_max) begin
                    rpt_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            REPORT: begin
                rpt_valid = 1'b1;
                if (rpt_ready) state_d = HOLD;
            end
            HOLD: begin
                if (dl_clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            origin_q <= '0;
            cnt_q    <= '0;
            vis_q    <= '0;
            rid_q    <= '0;
            rmask_q  <= '0;
            rlen_q   <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            cnt_q    <= cnt_d;
            vis_q    <= vis_d;
            rid_q    <= rid_d;
            rmask_q  <= rmask_d;
            rlen_q   <= rlen_d;
        end
    end

    assign rpt_origin_id = rid_q;
    assign rpt_proc_mask = rmask_q;
    assign rpt_len       = rlen_q;

endmodule

// File: tb/tb_blk_69f224.sv
// Randomized episode-level bench for blk_69f224 with a behavioural
// expectation model and a per-cycle compare process.
module tb_blk_69f224;

    localparam int P    = 4;
    localparam int W    = 3;
    localparam int TMAX = 1 << W;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [P-1:0] dl_in_vec = '0;
    logic [P-1:0] proc_token_vec = '0;
    logic         dl_clear = 1'b0;
    logic         rpt_ready = 1'b0;
    logic         dl_detect_out;
    logic [P-1:0] origin_vec;
    logic         token_clear;
    logic         rpt_valid;
    logic [4:0]   rpt_origin_id;
    logic [P-1:0] rpt_proc_mask;
    logic [W-1:0] rpt_len;
    logic         rpt_abort;

    blk_69f224 #(.PROC_NUM(P), .CNT_W(W)) dut (
        .reset          (reset),
        .clock          (clock),
        .dl_in_vec      (dl_in_vec),
        .proc_token_vec (proc_token_vec),
        .dl_clear       (dl_clear),
        .dl_detect_out  (dl_detect_out),
        .origin_vec     (origin_vec),
        .token_clear    (token_clear),
        .rpt_valid      (rpt_valid),
        .rpt_ready      (rpt_ready),
        .rpt_origin_id  (rpt_origin_id),
        .rpt_proc_mask  (rpt_proc_mask),
        .rpt_len        (rpt_len),
        .rpt_abort      (rpt_abort)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    bit           e_chk = 1'b0;
    bit           e_pay = 1'b0;
    logic         e_det, e_tclr, e_val, e_abort;
    logic [P-1:0] e_ovec;
    logic [4:0]   e_id;
    logic [P-1:0] e_mask;
    logic [W-1:0] e_len;

    logic [P-1:0] dir_tok [3];
    bit           directed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (e_chk) begin
            chk("dl_detect_out", 32'(dl_detect_out), 32'(e_det));
            chk("origin_vec", 32'(origin_vec), 32'(e_ovec));
            chk("token_clear", 32'(token_clear), 32'(e_tclr));
            chk("rpt_valid", 32'(rpt_valid), 32'(e_val));
            chk("rpt_abort", 32'(rpt_abort), 32'(e_abort));
            if (e_pay) begin
                chk("rpt_origin_id", 32'(rpt_origin_id), 32'(e_id));
                chk("rpt_proc_mask", 32'(rpt_proc_mask), 32'(e_mask));
                chk("rpt_len", 32'(rpt_len), 32'(e_len));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic lit_sync();
        @(negedge clock);
        #1;
    endtask

    function automatic int lowest(input logic [P-1:0] v);
        int r = 0;
        for (int i = P - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic exp_state(input logic det, input logic [P-1:0] ovec,
                             input logic tclr, input logic val,
                             input logic ab);
        e_det   = det;
        e_ovec  = ovec;
        e_tclr  = tclr;
        e_val   = val;
        e_abort = ab;
        e_pay   = 1'b0;
    endtask

    task automatic rand_side();
        proc_token_vec = P'($urandom);
        dl_clear       = 1'($urandom);
        rpt_ready      = 1'($urandom);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            dl_in_vec = '0;
            rand_side();
            exp_state(0, '0, 0, 0, 0);
            cyc();
        end
    endtask

    // len == 0 means the token never returns; rst_at > 0 resets in that
    // trace cycle.
    task automatic episode(input logic [P-1:0] dv, input int len,
                           input int rdly, input int hold, input int rst_at);
        int           o;
        int           n;
        logic [P-1:0] om;
        logic [P-1:0] tok;
        logic [P-1:0] vis;
        logic [W-1:0] elen;
        dl_in_vec = dv;
        rand_side();
        exp_state(0, '0, 0, 0, 0);
        cyc();
        o     = lowest(dv);
        om    = '0;
        om[o] = 1'b1;
        dl_in_vec = P'($urandom);
        rand_side();
        exp_state(1, om, 0, 0, 0);
        if (directed) begin
            lit_sync();
            chk("lit_origin_vec", 32'(origin_vec), 32'h2);
            chk("lit_detect", 32'(dl_detect_out), 32'h1);
        end
        cyc();
        vis = '0;
        n   = (len == 0) ? TMAX : len;
        for (int t = 1; t <= n; t++) begin
            tok = P'($urandom) & ~om;
            if (t == len) tok = tok | om;
            if (directed) tok = dir_tok[t-1];
            vis            = vis | tok;
            proc_token_vec = tok;
            dl_in_vec      = P'($urandom);
            dl_clear       = 1'($urandom);
            rpt_ready      = 1'($urandom);
            if (t == rst_at) begin
                reset = 1'b0;
                exp_state(0, '0, 0, 0, 0);
                e_pay  = 1'b1;
                e_id   = '0;
                e_mask = '0;
                e_len  = '0;
                cyc();
                cyc();
                reset = 1'b1;
                return;
            end
            exp_state(1, '0, t == len, 0, len == 0 && t == TMAX);
            if (directed) begin
                lit_sync();
                chk("lit_token_clear", 32'(token_clear), 32'(t == 3));
            end
            cyc();
        end
        if (len == 0) return;
        elen = (len > TMAX - 1) ? W'(TMAX - 1) : W'(len);
        for (int r = 0; r <= rdly; r++) begin
            rpt_ready      = (r == rdly);
            dl_clear       = 1'($urandom);
            dl_in_vec      = P'($urandom);
            proc_token_vec = P'($urandom);
            exp_state(1, '0, 0, 1, 0);
            e_pay  = 1'b1;
            e_id   = 5'(o);
            e_mask = vis;
            e_len  = elen;
            if (directed) begin
                lit_sync();
                chk("lit_rpt_len", 32'(rpt_len), 32'd3);
                chk("lit_rpt_mask", 32'(rpt_proc_mask), 32'he);
                chk("lit_rpt_id", 32'(rpt_origin_id), 32'd1);
            end
            cyc();
        end
        for (int h = 0; h <= hold; h++) begin
            dl_clear       = (h == hold);
            dl_in_vec      = P'($urandom);
            proc_token_vec = P'($urandom);
            rpt_ready      = 1'($urandom);
            exp_state(1, '0, 0, 0, 0);
            cyc();
        end
    endtask

    initial begin
        dir_tok[0] = 4'b0100;
        dir_tok[1] = 4'b1000;
        dir_tok[2] = 4'b0010;
        exp_state(0, '0, 0, 0, 0);
        e_pay  = 1'b1;
        e_id   = '0;
        e_mask = '0;
        e_len  = '0;
        e_chk  = 1'b1;
        #1;
        cyc();
        cyc();
        reset = 1'b1;
        idle_cycles(2);

        directed = 1'b1;
        episode(4'b0110, 3, 5, 2, 0);
        directed = 1'b0;
        idle_cycles(1);
        lit_sync();
        chk("lit_idle_detect", 32'(dl_detect_out), 32'h0);
        cyc();

        episode(4'b1000, 0, 0, 0, 0);
        idle_cycles(2);
        episode(4'b0110, 0, 0, 0, 2);
        idle_cycles(2);
        episode(4'b0001, TMAX, 0, 0, 0);
        idle_cycles(1);

        for (int ep = 0; ep < 80; ep++) begin
            int len;
            int ra;
            len = $urandom_range(0, TMAX);
            ra  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, TMAX) : 0;
            if (len != 0 && ra > len) ra = 0;
            episode(P'($urandom_range(1, (1 << P) - 1)), len,
                    $urandom_range(0, 5), $urandom_range(0, 3), ra);
            idle_cycles($urandom_range(1, 3));
        end

        e_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blk_69f224.md
ETHERNET_HEADER_INSERTER_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: ethernet_header_inserter_hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4, number of monitored dataflow processes (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the trace cycle counter.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port dl_in_vec  input  PROC_NUM  per-process dl_detect_out from each detect unit.
REQ-006 SHALL have port proc_token_vec  input  PROC_NUM  bit i = OR of token_in_vec of process i.
REQ-007 SHALL have port dl_clear  input  1  software request to re-arm after a report.
REQ-008 SHALL have port dl_detect_out  output  1  global flag, fanned out to every unit's dl_detect_in.
REQ-009 SHALL have port origin_vec  output  PROC_NUM  one-hot origin pulse to the selected unit.
REQ-010 SHALL have port token_clear  output  1  combinational; stops token circulation at the origin.
REQ-011 SHALL have port rpt_valid  output  1, rpt_ready  input  1  report handshake.
REQ-012 SHALL have ports rpt_origin_id  output  5, rpt_proc_mask  output  PROC_NUM, rpt_len  output  CNT_W  report payload.
REQ-013 SHALL have port rpt_abort  output  1  one-cycle pulse on trace timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ORIGIN, TRACE, REPORT, HOLD.
REQ-015 IDLE: when |dl_in_vec, SHALL latch origin_id = lowest set index and go to ORIGIN next cycle; otherwise stay.
REQ-016 ORIGIN (exactly one cycle): origin_vec = 1<<origin_id, dl_detect_out = 1; trace_cnt and visited mask cleared; next state TRACE.
REQ-017 dl_detect_out SHALL be 1 in ORIGIN, TRACE, REPORT, HOLD and 0 in IDLE; origin_vec SHALL be 0 outside ORIGIN.
REQ-018 TRACE: every cycle visited |= proc_token_vec and trace_cnt increments by 1, saturating at all-ones.
REQ-019 TRACE: token_clear = proc_token_vec[origin_id], combinational, same cycle; in that cycle SHALL capture rpt_len = trace_cnt+1, rpt_proc_mask = visited | proc_token_vec, rpt_origin_id = origin_id, then go to REPORT.
REQ-020 token_clear SHALL be 0 in every state other than TRACE.
REQ-021 TRACE timeout: if trace_cnt equals all-ones and no return seen, SHALL pulse rpt_abort for one cycle and go to IDLE (dl_detect_out drops next cycle).
REQ-022 REPORT: rpt_valid = 1 with payload stable until rpt_ready sampled 1; then go to HOLD; rpt_valid 0 in all other states.
REQ-023 HOLD: remain until dl_clear = 1, then go to IDLE; dl_clear SHALL be ignored in all other states.
REQ-024 dl_in_vec changes after leaving IDLE SHALL not alter origin_id or the state sequence.
REQ-025 If rpt_ready is 1 in the first REPORT cycle, SHALL spend exactly one cycle in REPORT.
REQ-026 rpt_origin_id SHALL be zero-extended to 5 bits.

Reset
REQ-027 On reset low, SHALL asynchronously enter IDLE with dl_detect_out, origin_vec, rpt_valid, rpt_abort = 0, rpt_* payload, trace_cnt, visited = 0.
REQ-028 Reset asserted in any state, including mid-TRACE or with rpt_valid high, SHALL abort without a report or abort pulse.
REQ-029 After reset release, SHALL be in IDLE on the first rising edge.

Verification
REQ-030 PROC_NUM=4: dl_in_vec=4'b0110 at cycle N -> origin_vec=4'b0010 and dl_detect_out=1 at N+1; TRACE from N+2.
REQ-031 Token ring 1->2->3->1: proc_token_vec = 0100, 1000, 0010 over three TRACE cycles -> token_clear=1 only in the third; rpt_len=3, rpt_proc_mask=4'b1110, rpt_origin_id=1.
REQ-032 rpt_ready held 0 for 5 cycles, then 1 -> rpt_valid high 6 cycles with stable payload; then HOLD; dl_clear=1 -> IDLE, dl_detect_out=0 next cycle.
REQ-033 CNT_W=3, token never returns -> rpt_abort pulse after 8 TRACE cycles, rpt_valid never asserts, IDLE next.
REQ-034 reset low during the 2nd TRACE cycle -> all outputs 0 immediately, IDLE; dl_clear pulsed in TRACE -> no effect.
